reg4_write_arbiter: RTL and testbench

REG4_WRITE_ARBITER -- requirements
Module: reg4_write_arbiter

---
 rtl/reg4_write_arbiter.sv | 124 ++++++++++++
 tb/tb_reg4_write_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg4_write_arbiter.sv
// reg4_write_arbiter
// Arbitrates write requests from two requesters onto a 4-bit SR-latch register.
// Each write clears the bits that must end low (R pulse), idles one cycle,
// sets the bits that must end high (S pulse), then reads the latch back and
// acknowledges the requester with a readback-mismatch flag.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   req0, data0  write request / target value from requester 0
//   req1, data1  write request / target value from requester 1
//   ack0, ack1   one-cycle completion pulses
//   err          readback mismatch, valid only in the ack cycle
//   busy         high whenever a write is in progress
//   S, R         per-bit set / reset drive to the latch register
//   Q            latch register outputs, read back
module reg4_write_arbiter #(
   parameter int unsigned PULSE_LEN = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic [3:0] data0,
   input  logic       req1,
   input  logic [3:0] data1,
   output logic       ack0,
   output logic       ack1,
   output logic       err,
   output logic       busy,
   output logic [3:0] S,
   output logic [3:0] R,
   input  logic [3:0] Q
);

   localparam int unsigned DATA_W = 4;
   localparam int unsigned CNT_W  = 4;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      GAP,
      SET,
      CHECK,
      DONE
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] tgt;
   logic [CNT_W-1:0]  pulseCnt;
   logic              grantOne;
   logic              prioOne;
   logic              pickOne;

   // Round-robin pick: a lone requester always wins, a tie goes to prioOne.
   assign pickOne = req1 && (!req0 || prioOne);

   // Write sequencer. The output registers present the drive belonging to
   // the state occupied during the previous cycle, so every output is a flop
   // and the readback compare happens in the quiet cycle after SET.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tgt      <= '0;
         pulseCnt <= '0;
         grantOne <= 1'b0;
         prioOne  <= 1'b0;
         S        <= '0;
         R        <= '0;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         err      <= 1'b0;
         busy     <= 1'b0;
      end else begin
         S    <= (state == SET)   ? tgt  : '0;
         R    <= (state == CLEAR) ? ~tgt : '0;
         busy <= (state != IDLE);
         ack0 <= (state == DONE) && !grantOne;
         ack1 <= (state == DONE) && grantOne;
         // Q is sampled after the last S pulse has been released.
         err  <= (state == DONE) && (Q != tgt);

         unique case (state)
            IDLE: begin
               if (req0 || req1) begin
                  grantOne <= pickOne;
                  prioOne  <= !pickOne;
                  tgt      <= pickOne ? data1 : data0;
                  pulseCnt <= CNT_LOAD;
                  state    <= CLEAR;
               end
            end
            CLEAR: begin
               if (pulseCnt == '0) begin
                  state <= GAP;
               end else begin
                  pulseCnt <= pulseCnt - CNT_W'(1);
               end
            end
            GAP: begin
               pulseCnt <= CNT_LOAD;
               state    <= SET;
            end
            SET: begin
               if (pulseCnt == '0) begin
                  state <= CHECK;
               end else begin
                  pulseCnt <= pulseCnt - CNT_W'(1);
               end
            end
            CHECK: begin
               state <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg4_write_arbiter.sv
// Self-checking bench for reg4_write_arbiter with a transaction-level model.
module tb_reg4_write_arbiter;

   localparam int P   = 2;
   localparam int LAT = 2 * P + 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1;
   logic [3:0] data0, data1;
   logic       ack0, ack1, err, busy;
   logic [3:0] S, R, Q;
   logic [3:0] qLatch = 4'b0000;
   logic       stuck = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Latch register model; stuck forces a readback fault.
   assign Q = stuck ? 4'b0000 : qLatch;
   always @(posedge clk) qLatch <= (qLatch & ~R) | S;
   always #5 clk = ~clk;

   reg4_write_arbiter #(.PULSE_LEN(P)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .data0(data0), .req1(req1), .data1(data1),
      .ack0(ack0), .ack1(ack1), .err(err), .busy(busy),
      .S(S), .R(R), .Q(Q)
   );

   // Model: a transaction is a timeline of offsets from its grant edge.
   bit         mActive = 1'b0;
   bit         mWho = 1'b0;
   bit         mPrio1 = 1'b0;
   int         mk = 0;
   logic [3:0] mTgt = 4'b0000;
   logic [11:0] expOut = '0;
   int         grantQ[$];

   function automatic logic [11:0] obsOut();
      return {ack0, ack1, err, busy, S, R};
   endfunction

   task automatic model_step();
      logic [3:0] eS, eR;
      logic eA0, eA1, eE, eB;
      eS = '0; eR = '0; eA0 = 0; eA1 = 0; eE = 0; eB = 0;
      if (rst) begin
         mActive = 0;
         mPrio1  = 0;
      end else if (mActive) begin
         mk++;
         eB = 1;
         if (mk <= P) eR = ~mTgt;
         else if (mk >= P + 2 && mk <= 2 * P + 1) eS = mTgt;
         if (mk == LAT) begin
            eA0 = !mWho;
            eA1 = mWho;
            eE = stuck && (mTgt != 4'b0000);
            mActive = 0;
         end
      end else if (req0 || req1) begin
         if (req0 && req1) mWho = mPrio1;
         else mWho = req1;
         mPrio1 = !mWho;
         mTgt = mWho ? data1 : data0;
         mActive = 1;
         mk = 0;
         grantQ.push_back(int'(mWho));
      end
      expOut = {eA0, eA1, eE, eB, eS, eR};
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1; req0 = 0; req1 = 0;
      tick();
      rst = 0;
      grantQ.delete();
   endtask

   // Invariant monitor: no S/R overlap, no S/R adjacency, no double ack.
   initial begin
      logic [3:0] prevS, prevR;
      prevS = '0; prevR = '0;
      forever begin
         @(negedge clk);
         checks++;
         if (((S & R) != 0) || ((prevR & S) != 0) || ((prevS & R) != 0) || (ack0 && ack1)) begin
            errors++;
            $display("FAIL invariant cyc %0d: S=%b R=%b prevS=%b prevR=%b ack0=%b ack1=%b",
                     cyc, S, R, prevS, prevR, ack0, ack1);
         end
         prevS = S;
         prevR = R;
      end
   end

   task automatic test_reset();
      rst = 1; req0 = 1; req1 = 1; data0 = 4'hA; data1 = 4'h5;
      tick(); tick();
      checks++;
      if (obsOut() !== 12'h000) begin
         errors++;
         $display("FAIL reset_values: got %b expected %b", obsOut(), 12'h000);
      end
      checks++;
      if (obsOut() !== expOut) begin
         errors++;
         $display("FAIL reset_model: got %b expected %b", obsOut(), expOut);
      end
      rst = 0; req0 = 0; req1 = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (obsOut() !== 12'h000) begin
            errors++;
            $display("FAIL reset_idle cyc %0d: got %b expected %b", cyc, obsOut(), 12'h000);
         end
      end
   endtask

   task automatic test_single_write(input logic [3:0] v, input bit who, input string name);
      int lat, rc, sc;
      lat = -1; rc = 0; sc = 0;
      do_reset();
      if (who) begin req1 = 1; data1 = v; end
      else begin req0 = 1; data0 = v; end
      for (int i = 1; i <= LAT + 3; i++) begin
         tick();
         checks++;
         if (obsOut() !== expOut) begin
            errors++;
            $display("FAIL %s cyc %0d: got %b expected %b", name, cyc, obsOut(), expOut);
         end
         if (busy && R == ~v && R != 0) rc++;
         if (busy && S == v && S != 0) sc++;
         if ((who ? ack1 : ack0) && lat < 0) begin
            lat = i - 1;
            req0 = 0; req1 = 0;
            checks++;
            if (err !== 1'b0) begin
               errors++;
               $display("FAIL %s_err: got %b expected 0", name, err);
            end
         end
      end
      checks++;
      if (lat != LAT) begin
         errors++;
         $display("FAIL %s_latency: got %0d expected %0d", name, lat, LAT);
      end
      checks++;
      if (rc != ((v == 4'hF) ? 0 : P) || sc != ((v == 4'h0) ? 0 : P)) begin
         errors++;
         $display("FAIL %s_pulses: got R=%0d S=%0d expected R=%0d S=%0d", name, rc, sc,
                  (v == 4'hF) ? 0 : P, (v == 4'h0) ? 0 : P);
      end
      checks++;
      if (Q !== v) begin
         errors++;
         $display("FAIL %s_readback: got %b expected %b", name, Q, v);
      end
   endtask

   task automatic test_contention();
      int a0, a1;
      a0 = -1; a1 = -1;
      do_reset();
      req0 = 1; req1 = 1; data0 = 4'($urandom); data1 = 4'($urandom);
      for (int i = 1; i <= 3 * LAT; i++) begin
         tick();
         checks++;
         if (obsOut() !== expOut) begin
            errors++;
            $display("FAIL contention cyc %0d: got %b expected %b", cyc, obsOut(), expOut);
         end
         if (ack0) begin a0 = i; req0 = 0; end
         if (ack1) begin a1 = i; req1 = 0; end
      end
      checks++;
      if (a0 != LAT + 1 || a1 != 2 * LAT + 2) begin
         errors++;
         $display("FAIL contention_order: got ack0@%0d ack1@%0d expected ack0@%0d ack1@%0d",
                  a0, a1, LAT + 1, 2 * LAT + 2);
      end
   endtask

   task automatic test_round_robin();
      int order[$];
      int rrExp[4];
      rrExp = '{0, 1, 0, 1};
      do_reset();
      req0 = 1; req1 = 1; data0 = 4'($urandom); data1 = 4'($urandom);
      for (int i = 0; i < 5 * (LAT + 1) && order.size() < 4; i++) begin
         tick();
         checks++;
         if (obsOut() !== expOut) begin
            errors++;
            $display("FAIL round_robin cyc %0d: got %b expected %b", cyc, obsOut(), expOut);
         end
         if (ack0) order.push_back(0);
         if (ack1) order.push_back(1);
      end
      req0 = 0; req1 = 0;
      checks++;
      if (order.size() != 4) begin
         errors++;
         $display("FAIL round_robin_count: got %0d acks expected 4", order.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (order[i] != rrExp[i] || order[i] != grantQ[i]) begin
               errors++;
               $display("FAIL round_robin_grant%0d: got %0d expected %0d", i, order[i], rrExp[i]);
            end
         end
      end
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_data_change();
      int acks;
      acks = 0;
      do_reset();
      req0 = 1; data0 = 4'($urandom);
      tick();
      data0 = ~data0; req0 = 0;
      for (int i = 0; i < LAT + 2; i++) begin
         tick();
         checks++;
         if (obsOut() !== expOut) begin
            errors++;
            $display("FAIL data_change cyc %0d: got %b expected %b", cyc, obsOut(), expOut);
         end
         if (ack0) acks++;
      end
      checks++;
      if (acks != 1 || Q !== ~data0) begin
         errors++;
         $display("FAIL data_change_result: got acks=%0d Q=%b expected acks=1 Q=%b", acks, Q, ~data0);
      end
   endtask

   task automatic test_readback_fault();
      int seen;
      seen = 0;
      do_reset();
      stuck = 1;
      req1 = 1; data1 = 4'b0110;
      for (int i = 0; i < LAT + 3; i++) begin
         tick();
         checks++;
         if (obsOut() !== expOut) begin
            errors++;
            $display("FAIL readback_fault cyc %0d: got %b expected %b", cyc, obsOut(), expOut);
         end
         if (ack1) begin
            seen++;
            req1 = 0;
            checks++;
            if (err !== 1'b1) begin
               errors++;
               $display("FAIL readback_fault_err: got %b expected 1", err);
            end
         end
      end
      stuck = 0;
      checks++;
      if (seen != 1) begin
         errors++;
         $display("FAIL readback_fault_ack: got %0d acks expected 1", seen);
      end
   endtask

   task automatic test_reset_mid_set();
      int n, acks;
      n = 0; acks = 0;
      do_reset();
      req0 = 1; data0 = 4'($urandom_range(1, 15));
      while (S === 4'b0000 && n < LAT + 2) begin
         tick();
         n++;
      end
      checks++;
      if (S === 4'b0000) begin
         errors++;
         $display("FAIL reset_mid_set_wait: got no SET phase within %0d cycles", n);
      end
      rst = 1; req0 = 0;
      tick();
      checks++;
      if ({S, R, busy, ack0, ack1, err} !== 12'h000) begin
         errors++;
         $display("FAIL reset_mid_set_abort: got S=%b R=%b busy=%b ack=%b%b err=%b expected all 0",
                  S, R, busy, ack0, ack1, err);
      end
      rst = 0;
      for (int i = 0; i < LAT + 2; i++) begin
         tick();
         if (ack0 || ack1) acks++;
      end
      checks++;
      if (acks != 0) begin
         errors++;
         $display("FAIL reset_mid_set_noack: got %0d acks expected 0", acks);
      end
      test_single_write(4'($urandom), 1'b1, "after_abort");
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if (!req0 && $urandom_range(0, 3) == 0) begin req0 = 1; data0 = 4'($urandom); end
         if (!req1 && $urandom_range(0, 3) == 0) begin req1 = 1; data1 = 4'($urandom); end
         tick();
         checks++;
         if (obsOut() !== expOut) begin
            errors++;
            $display("FAIL random cyc %0d: got %b expected %b", cyc, obsOut(), expOut);
         end
         if (ack0) req0 = 0;
         if (ack1) req1 = 0;
      end
      req0 = 0; req1 = 0;
      for (int i = 0; i < LAT + 2; i++) begin
         tick();
         checks++;
         if (obsOut() !== expOut) begin
            errors++;
            $display("FAIL random_drain cyc %0d: got %b expected %b", cyc, obsOut(), expOut);
         end
      end
      checks++;
      if (Q !== mTgt) begin
         errors++;
         $display("FAIL random_final_q: got %b expected %b", Q, mTgt);
      end
   endtask

   initial begin
      rst = 1; req0 = 0; req1 = 0; data0 = '0; data1 = '0;
      test_reset();
      test_single_write(4'b1010, 1'b0, "single_write");
      test_single_write(4'b1111, 1'b1, "all_ones");
      test_single_write(4'b0000, 1'b0, "all_zeros");
      test_contention();
      test_round_robin();
      test_data_change();
      test_readback_fault();
      test_reset_mid_set();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
